s_memory_init_task: RTL

//  Responder side of the controller's Task1 start/stop handshake. On a start

---
 rtl/l4_pkg.sv | 16 +
 rtl/s_memory_init_task_up_counter.sv | 36 +++
 rtl/s_memory_init_task.sv | 113 +++++++++++
 3 files changed

// File: rtl/l4_pkg.sv
// Shared definitions for the level-4 task handshake blocks and the S working memory.
package l4_pkg;

   // Task status as seen by both the controller FSM and the task responders.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } task_state_t;

   // Geometry of the S working memory.
   localparam int S_DEPTH  = 256;
   localparam int S_ADDR_W = 8;
   localparam int S_DATA_W = 8;

endpackage

// File: rtl/s_memory_init_task_up_counter.sv
// Up counter with synchronous clear and count enable; generates the S-memory write index.
module up_counter #(
   parameter int WIDTH = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // Next count: clear wins over enable, otherwise hold.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // Count register with asynchronous reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/s_memory_init_task.sv
// Task1 responder: on a start request fills S memory with S[i] = i, then acknowledges.
module s_memory_init_task
   import l4_pkg::*;
#(
   parameter int ADDR_WIDTH = S_ADDR_W,
   parameter int DATA_WIDTH = S_DATA_W,
   parameter int DEPTH      = S_DEPTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  startTask1,
   output logic                  stopTask1,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  wren,
   output logic                  busy
);

   // One extra bit so DEPTH = 2**ADDR_WIDTH reaches its last index without wrapping.
   localparam int             CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

   task_state_t           state_q, state_d;
   logic                  stop_q, stop_d;
   logic                  wren_q, wren_d;
   logic                  busy_q, busy_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]      count;
   logic                  cnt_clear;
   logic                  cnt_en;

   // Index restarts at 0 whenever no fill is in progress.
   assign cnt_clear = (state_q != WRITE);
   assign cnt_en    = (state_q == WRITE);

   up_counter #(
      .WIDTH (CNT_W)
   ) u_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (cnt_clear),
      .enable (cnt_en),
      .count  (count)
   );

   // Next-state and next-output logic; address/data hold outside WRITE.
   always_comb begin
      state_d = state_q;
      stop_d  = stop_q;
      wren_d  = 1'b0;
      busy_d  = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            stop_d = 1'b0;
            if (startTask1) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            wren_d = 1'b1;
            busy_d = 1'b1;
            addr_d = ADDR_WIDTH'(count);
            data_d = DATA_WIDTH'(count);
            if (count == LAST) begin
               state_d = DONE;
            end
         end
         DONE: begin
            // The acknowledge is raised for at least one cycle before start is
            // re-examined, so a start already dropped mid-fill is still answered.
            if (stop_q && !startTask1) begin
               state_d = IDLE;
               stop_d  = 1'b0;
            end else begin
               stop_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            stop_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset clears everything immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         stop_q  <= 1'b0;
         wren_q  <= 1'b0;
         busy_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         stop_q  <= stop_d;
         wren_q  <= wren_d;
         busy_q  <= busy_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign stopTask1 = stop_q;
   assign wren      = wren_q;
   assign busy      = busy_q;
   assign address   = addr_q;
   assign data      = data_q;

endmodule
